// File: rtl/sa_pkg.sv
// Shared definitions for the 4x4 output-stationary systolic array: sizes,
// FSM states, the tagged operand that flows through the PE mesh.
package sa_pkg;

  localparam int SA_DIM       = 4;
  localparam int DATA_W       = 8;
  localparam int ACC_W        = 32;
  localparam int FLUSH_CYCLES = 2 * (SA_DIM - 1) + 1;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    OUT
  } sa_state_t;

  // Operand plus the tags that ride along with it through skew and mesh.
  typedef struct packed {
    logic                     valid;
    logic                     first;
    logic signed [DATA_W-1:0] data;
  } sa_opnd_t;

  // Index of the last emitted row: enables count as a leading-ones prefix.
  function automatic logic [1:0] last_row_of(input logic [SA_DIM-2:0] row_en);
    if (!row_en[0])      return 2'd0;
    else if (!row_en[1]) return 2'd1;
    else if (!row_en[2]) return 2'd2;
    else                 return 2'd3;
  endfunction

endpackage

// File: rtl/systolic_array_4x4_pe.sv
// One processing element: signed 8x8 multiply into a 32-bit accumulator,
// with registered pass-through of both operands toward the neighbours.
module sa_pe
  import sa_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  sa_opnd_t                w_in,
  input  sa_opnd_t                x_in,
  output sa_opnd_t                w_out,
  output sa_opnd_t                x_out,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign prod     = w_in.data * x_in.data;
  assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

  // NOTE: sequential state uses <= so every PE samples its neighbours' pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_out <= '0;
      x_out <= '0;
      acc   <= '0;
    end else begin
      w_out <= w_in;
      x_out <= x_in;
      // Beat 0 overwrites the previous tile's sum, so no explicit clear exists.
      if (w_in.valid && x_in.valid)
        acc <= w_in.first ? prod_ext : acc + prod_ext;
    end
  end

endmodule

// File: rtl/systolic_array_4x4.sv
// 4x4 int8 output-stationary systolic array: skews operand columns into the
// PE mesh, flushes the wavefront, then drains the int32 tile row by row.
module systolic_array_4x4
  import sa_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sa_start,
  input  logic [SA_DIM-2:0]        sa_row_en,
  input  logic                     sa_i_valid,
  input  logic                     sa_i_last,
  input  logic [SA_DIM*DATA_W-1:0] sa_weight,
  input  logic [SA_DIM*DATA_W-1:0] sa_input,
  output logic                     sa_busy,
  output logic                     sa_o_valid,
  output logic                     sa_o_last,
  output logic [SA_DIM*ACC_W-1:0]  sa_o_data
);

  sa_state_t               state;
  logic                    first_pending;
  logic [1:0]              last_row;
  logic [1:0]              out_row;
  logic [1:0]              nxt_row;
  logic [2:0]              flush_cnt;
  logic                    beat_acc;
  logic                    unused_edge;

  sa_opnd_t                w_bus   [SA_DIM][SA_DIM+1];
  sa_opnd_t                x_bus   [SA_DIM+1][SA_DIM];
  logic signed [ACC_W-1:0] acc     [SA_DIM][SA_DIM];
  logic [SA_DIM*ACC_W-1:0] acc_row [SA_DIM];
  logic [SA_DIM*ACC_W-1:0] shadow  [SA_DIM];

  assign beat_acc = (state == FEED) && sa_i_valid;
  assign sa_busy  = (state != IDLE);
  assign nxt_row  = out_row + 2'd1;

  // Row i of weights and column i of inputs both need an i-cycle delay.
  for (genvar i = 0; i < SA_DIM; i++) begin : g_skew
    sa_opnd_t w_src;
    sa_opnd_t x_src;

    assign w_src = {beat_acc, beat_acc & first_pending,
                    sa_weight[i*DATA_W +: DATA_W] & {DATA_W{beat_acc}}};
    assign x_src = {beat_acc, beat_acc & first_pending,
                    sa_input[i*DATA_W +: DATA_W] & {DATA_W{beat_acc}}};

    if (i == 0) begin : g_direct
      assign w_bus[0][0] = w_src;
      assign x_bus[0][0] = x_src;
    end else begin : g_dly
      sa_opnd_t w_pipe [i];
      sa_opnd_t x_pipe [i];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < i; s++) begin
            w_pipe[s] <= '0;
            x_pipe[s] <= '0;
          end
        end else begin
          w_pipe[0] <= w_src;
          x_pipe[0] <= x_src;
          for (int s = 1; s < i; s++) begin
            w_pipe[s] <= w_pipe[s-1];
            x_pipe[s] <= x_pipe[s-1];
          end
        end
      end

      assign w_bus[i][0] = w_pipe[i-1];
      assign x_bus[0][i] = x_pipe[i-1];
    end
  end

  for (genvar r = 0; r < SA_DIM; r++) begin : g_row
    for (genvar c = 0; c < SA_DIM; c++) begin : g_col
      sa_pe u_pe (
        .clk   (clk),
        .rst   (rst),
        .w_in  (w_bus[r][c]),
        .x_in  (x_bus[r][c]),
        .w_out (w_bus[r][c+1]),
        .x_out (x_bus[r+1][c]),
        .acc   (acc[r][c])
      );
    end
  end

  // Operands leaving the right and bottom edges are dead ends.
  always_comb begin
    unused_edge = 1'b0;
    for (int i = 0; i < SA_DIM; i++)
      unused_edge = unused_edge ^ (^{w_bus[i][SA_DIM], x_bus[SA_DIM][i]});
  end

  // NOTE: every always_comb output gets a full default first, so no latch can be inferred.
  always_comb begin
    acc_row = '{default: '0};
    for (int r = 0; r < SA_DIM; r++)
      for (int c = 0; c < SA_DIM; c++)
        acc_row[r][c*ACC_W +: ACC_W] = acc[r][c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      first_pending <= 1'b0;
      last_row      <= '0;
      out_row       <= '0;
      flush_cnt     <= '0;
      sa_o_valid    <= 1'b0;
      sa_o_last     <= 1'b0;
      sa_o_data     <= '0;
      // NOTE: the shadow is a small flop array, not a RAM, so it takes the reset too.
      for (int r = 0; r < SA_DIM; r++) shadow[r] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sa_start) begin
            state         <= FEED;
            first_pending <= 1'b1;
            last_row      <= last_row_of(sa_row_en);
          end
        end
        FEED: begin
          if (beat_acc) begin
            first_pending <= 1'b0;
            if (sa_i_last) begin
              state     <= FLUSH;
              flush_cnt <= '0;
            end
          end
        end
        FLUSH: begin
          // Final count: PE[3][3] has absorbed the last beat this cycle.
          if (flush_cnt == 3'(FLUSH_CYCLES - 1)) begin
            state      <= OUT;
            out_row    <= '0;
            sa_o_valid <= 1'b1;
            sa_o_last  <= (last_row == 2'd0);
            sa_o_data  <= acc_row[0];
            for (int r = 0; r < SA_DIM; r++) shadow[r] <= acc_row[r];
          end else begin
            flush_cnt <= flush_cnt + 3'd1;
          end
        end
        OUT: begin
          if (sa_o_last) begin
            state      <= IDLE;
            sa_o_valid <= 1'b0;
            sa_o_last  <= 1'b0;
          end else begin
            out_row   <= nxt_row;
            sa_o_data <= shadow[nxt_row];
            sa_o_last <= (nxt_row == last_row);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Directed bench for systolic_array_4x4: timing of the drain window, row
// enables, back-to-back tiles, input gaps and mid-tile reset.
module tb_systolic_array_4x4;

  logic         clk = 1'b0;
  logic         rst;
  logic         sa_start;
  logic [2:0]   sa_row_en;
  logic         sa_i_valid;
  logic         sa_i_last;
  logic [31:0]  sa_weight;
  logic [31:0]  sa_input;
  logic         sa_busy;
  logic         sa_o_valid;
  logic         sa_o_last;
  logic [127:0] sa_o_data;

  int           n_vec = 0;
  int           n_err = 0;
  logic [31:0]  wq [256];
  logic [31:0]  xq [256];
  int           k_len;

  systolic_array_4x4 dut (
    .clk        (clk),
    .rst        (rst),
    .sa_start   (sa_start),
    .sa_row_en  (sa_row_en),
    .sa_i_valid (sa_i_valid),
    .sa_i_last  (sa_i_last),
    .sa_weight  (sa_weight),
    .sa_input   (sa_input),
    .sa_busy    (sa_busy),
    .sa_o_valid (sa_o_valid),
    .sa_o_last  (sa_o_last),
    .sa_o_data  (sa_o_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference matmul over the current beat list; int wraps mod 2^32.
  function automatic logic [127:0] exp_row(input int r);
    logic [127:0] row;
    row = '0;
    for (int c = 0; c < 4; c++) begin
      int sum;
      sum = 0;
      for (int k = 0; k < k_len; k++)
        sum += $signed(wq[k][8*r +: 8]) * $signed(xq[k][8*c +: 8]);
      row[32*c +: 32] = sum;
    end
    return row;
  endfunction

  task automatic fill_random(input int k);
    k_len = k;
    for (int i = 0; i < k; i++) begin
      wq[i] = $urandom;
      xq[i] = $urandom;
    end
  endtask

  task automatic start_tile(input logic [2:0] en);
    sa_start  = 1'b1;
    sa_row_en = en;
    tick();
    sa_start  = 1'b0;
    check("busy_after_start", sa_busy, 1);
  endtask

  // Gap cycles hold i_last high without i_valid; the DUT must ignore them.
  task automatic feed(input int gap_at, input int gap_len);
    for (int k = 0; k < k_len; k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          sa_i_valid = 1'b0;
          sa_i_last  = 1'b1;
          sa_weight  = $urandom;
          sa_input   = $urandom;
          tick();
        end
      end
      sa_i_valid = 1'b1;
      sa_i_last  = (k == k_len - 1);
      sa_weight  = wq[k];
      sa_input   = xq[k];
      tick();
    end
    sa_i_valid = 1'b0;
    sa_i_last  = 1'b0;
  endtask

  // Entered at cycle L+1; checks quiet L+7, rows at L+8.., idle afterwards.
  task automatic drain(input string tag, input int n_rows);
    repeat (6) tick();
    check({tag, "_quiet_at_L7"}, sa_o_valid, 0);
    check({tag, "_busy_at_L7"}, sa_busy, 1);
    for (int j = 0; j < n_rows; j++) begin
      tick();
      check($sformatf("%s_valid_row%0d", tag, j), sa_o_valid, 1);
      check($sformatf("%s_last_row%0d", tag, j), sa_o_last, (j == n_rows - 1) ? 1 : 0);
      check($sformatf("%s_data_row%0d", tag, j), sa_o_data, exp_row(j));
      check($sformatf("%s_busy_row%0d", tag, j), sa_busy, 1);
    end
    tick();
    check({tag, "_valid_after"}, sa_o_valid, 0);
    check({tag, "_busy_after"}, sa_busy, 0);
  endtask

  initial begin
    rst        = 1'b1;
    sa_start   = 1'b0;
    sa_row_en  = 3'b000;
    sa_i_valid = 1'b0;
    sa_i_last  = 1'b0;
    sa_weight  = '0;
    sa_input   = '0;
    k_len      = 0;
    repeat (3) tick();
    check("reset_busy", sa_busy, 0);
    check("reset_o_valid", sa_o_valid, 0);
    check("reset_o_last", sa_o_last, 0);
    check("reset_o_data", sa_o_data, 0);
    rst = 1'b0;
    tick();

    // K=1: row r holds r+1 in every column.
    k_len = 1;
    wq[0] = 32'h04030201;
    xq[0] = 32'h01010101;
    start_tile(3'b111);
    feed(-1, 0);
    drain("k1", 4);

    // Beats offered while idle must not start anything.
    sa_i_valid = 1'b1;
    sa_i_last  = 1'b1;
    sa_weight  = 32'hffffffff;
    sa_input   = 32'hffffffff;
    repeat (2) tick();
    sa_i_valid = 1'b0;
    sa_i_last  = 1'b0;
    check("idle_ignores_beats", sa_busy, 0);

    fill_random(7);
    start_tile(3'b111);
    feed(-1, 0);
    drain("k7_all", 4);

    fill_random(7);
    start_tile(3'b000);
    feed(-1, 0);
    drain("k7_row0", 1);

    // Non-prefix code 101 behaves as 001: rows 0-1.
    fill_random(4);
    start_tile(3'b101);
    feed(-1, 0);
    drain("k4_en101", 2);

    // K=256 of -128*-128 with start held through the whole tile.
    k_len = 256;
    for (int i = 0; i < 256; i++) begin
      wq[i] = 32'h80808080;
      xq[i] = 32'h80808080;
    end
    sa_start  = 1'b1;
    sa_row_en = 3'b111;
    tick();
    check("k256_busy_after_start", sa_busy, 1);
    feed(-1, 0);
    drain("k256", 4);
    tick();
    check("held_start_accepted", sa_busy, 1);
    sa_start = 1'b0;

    // Back-to-back tile with a 3-cycle gap mid-FEED.
    fill_random(5);
    feed(2, 3);
    drain("k5_gap", 4);

    // Reset in the middle of FEED abandons the tile.
    fill_random(3);
    start_tile(3'b111);
    for (int k = 0; k < 2; k++) begin
      sa_i_valid = 1'b1;
      sa_i_last  = 1'b0;
      sa_weight  = wq[k];
      sa_input   = xq[k];
      tick();
    end
    sa_i_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_busy", sa_busy, 0);
    check("midrst_o_valid", sa_o_valid, 0);
    check("midrst_o_last", sa_o_last, 0);
    check("midrst_o_data", sa_o_data, 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("postrst_busy", sa_busy, 0);
    check("postrst_o_valid", sa_o_valid, 0);

    fill_random(2);
    start_tile(3'b111);
    feed(-1, 0);
    drain("k2_after_rst", 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
